axi_rd_arbiter_2to1: RTL
========================

Name: axi_rd_arbiter_2to1

Overview:
- Sits directly upstream of the AXI4 memory slave and merges two NPC masters onto its single master port.
  - m0: IFU, read-only.
  - m1: LSU, read and write.
- Arbitrates the AR/R channels with one outstanding read burst at a time.
- Passes the LSU AW/W/B channels straight through.
- Blocks LSU reads while an LSU write is still awaiting its B response, so LSU read-after-write ordering is preserved.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; lanes pass through untouched, no byte reordering.
- ID_W, 4, AXI ID width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- m0_arvalid/m0_arready  in/out  1/1  IFU read-address handshake.
- m0_araddr/arid/arlen/arsize/arburst  in  ADDR_W/ID_W/8/3/2  IFU read-address payload.
- m0_rvalid/m0_rready  out/in  1/1  IFU read-data handshake.
- m0_rdata/rresp/rlast/rid  out  DATA_W/2/1/ID_W  IFU read-data payload.
- m1_ar*, m1_r*  same set as m0  LSU read channels.
- m1_aw*(valid,ready,addr,id,len,size,burst), m1_w*(valid,ready,data,strb,last), m1_b*(valid,ready,resp,id)  LSU write channels.
- s_ar*, s_r*, s_aw*, s_w*, s_b*  mirror directions  slave-side port to the memory.

Behaviour:
- Read FSM states: IDLE, AR0, AR1, R0, R1. Reset state is IDLE.
- IDLE:
  - All m*_arready = 0, s_arvalid = 0, m*_rvalid = 0, s_rready = 0.
  - Candidates: m0 if m0_arvalid; m1 if m1_arvalid && !wr_pend.
  - Choose a winner; next state is AR0 or AR1. Arbitration costs 1 cycle.
- ARx:
  - s_ar* = mx_ar*; s_arvalid = mx_arvalid; mx_arready = s_arready; the other master's arready = 0.
  - On s_arvalid && s_arready: go to Rx and update last_grant = x.
  - mx_arvalid must stay high (AXI rule). If it drops anyway, remain in ARx.
- Rx:
  - mx_r* = s_r*; mx_rvalid = s_rvalid; s_rready = mx_rready; the other master's rvalid = 0 and its rdata/rresp/rlast/rid are don't-care.
  - Beats are counted by the slave's rlast, not by arlen. The beat with s_rvalid && s_rready && s_rlast returns to IDLE.
  - Earliest new grant is the next cycle, so there is one idle cycle between bursts.
- Write path:
  - Combinational pass-through, m1_aw* <-> s_aw*, m1_w* <-> s_w*, s_b* <-> m1_b*.
  - wr_pend register: set on s_awvalid && s_awready; cleared on s_bvalid && s_bready.
  - If both happen in the same cycle, set wins.
  - If wr_pend is clear, the AW handshake in cycle N blocks an m1_arvalid that arrives in cycle N+1. Same-cycle AW and AR requests: the AR is blocked only from the next cycle, so the LSU must not issue both in the same cycle. wr_pend does not gate an already-granted AR1/R1.
- Simultaneous m0/m1 requests in IDLE resolve per the priority rule (see Optional Feature).
- ID and response fields are forwarded unchanged; rresp errors are not altered.
- Reset mid-burst:
  - FSM returns to IDLE, wr_pend = 0, last_grant = m1 (so m0 wins first under round-robin).
  - Slave-side state is the slave's own responsibility.
- Width rules: no arithmetic on addresses; all fields are passed bit-exact.

Optional Feature:
- Macro: AXI_ARB_RR_EN.
- Defined: round-robin priority. On contention the winner is the master other than last_grant.
- Undefined: fixed priority, m1 (LSU) always wins contention, and last_grant is unused. IFU starvation is accepted.

Decomposition:
- Shared package axi_arb_pkg:
  - State enum {IDLE, AR0, AR1, R0, R1}.
  - AXI burst constants FIXED=2'b00, INCR=2'b01.
  - RESP_OKAY = 2'b00.
- Sub-module arb_pick2: combinational 2-way picker taking req[1:0], last_grant and the macro. Returns the winner index. Kept separate so it can be reused by a future write arbiter.

Test Plan:
- m0 AR addr=0x8000_0000, arlen=3, INCR, slave returns 4 beats -> IFU sees 4 rvalid beats, rlast on beat 4 only; m1_rvalid stays 0; IDLE one cycle later.
- m0 and m1 AR in the same cycle, with AXI_ARB_RR_EN and reset just released -> m0 served first, then m1. Without the macro -> m1 served first.
- Back-to-back contention with AXI_ARB_RR_EN, 4 rounds -> grants alternate m0, m1, m0, m1.
- m1 AW 0x8000_0010 / W 0xDEADBEEF, strb=0xF, with the slave holding bvalid 5 cycles; m1 AR asserted the next cycle -> AR not forwarded until the cycle after the B handshake. An m0 AR in the meantime is granted.
- s_rready follows m1_rready; m1_rready toggled 1-0-1 during a 2-beat burst -> s_rready mirrors it exactly and no beat is lost or duplicated.
- reset asserted during beat 2 of a 4-beat R0 burst -> all m*_arready/rvalid = 0 asynchronously; after release, FSM in IDLE and a new m1 AR is granted within 2 cycles.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI read arbiter slice.
package axi_arb_pkg;

  // Read-path arbiter states: idle, address phase per master, data phase per master.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR0  = 3'd1,
    AR1  = 3'd2,
    R0   = 3'd3,
    R1   = 3'd4
  } rd_state_t;

  // AXI burst encodings.
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;

  // AXI response encoding for a normal completion.
  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/arb_pick2.sv
// Combinational 2-way picker. Returns the index of the winning requester.
// Build option AXI_ARB_RR_EN: round-robin on contention (the winner is the
// requester other than last_grant). Without it, requester 1 always wins.
// The result is meaningless when req is zero.
module arb_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

`ifdef AXI_ARB_RR_EN
  // On contention alternate away from the previous winner; otherwise take the lone requester.
  always_comb begin
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else begin
      grant = req[1];
    end
  end
`else
  // Fixed priority ignores history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Requester 1 wins whenever it asks.
  always_comb begin
    grant = req[1];
  end
`endif

endmodule

// File: rtl/axi_rd_arbiter_2to1.sv
// Merges the IFU (m0, read-only) and LSU (m1, read/write) AXI4 masters onto a
// single slave port. Reads are arbitrated one burst at a time; LSU writes pass
// straight through, and an LSU read is held back while an LSU write still
// awaits its B response. Build option AXI_ARB_RR_EN selects round-robin
// arbitration (see arb_pick2); default is fixed LSU priority.
module axi_rd_arbiter_2to1
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  // IFU read channels
  input  logic                m0_arvalid,
  output logic                m0_arready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [ID_W-1:0]     m0_arid,
  input  logic [7:0]          m0_arlen,
  input  logic [2:0]          m0_arsize,
  input  logic [1:0]          m0_arburst,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rlast,
  output logic [ID_W-1:0]     m0_rid,
  // LSU read channels
  input  logic                m1_arvalid,
  output logic                m1_arready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [ID_W-1:0]     m1_arid,
  input  logic [7:0]          m1_arlen,
  input  logic [2:0]          m1_arsize,
  input  logic [1:0]          m1_arburst,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rlast,
  output logic [ID_W-1:0]     m1_rid,
  // LSU write channels
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [ID_W-1:0]     m1_awid,
  input  logic [7:0]          m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic [1:0]          m1_awburst,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wlast,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [1:0]          m1_bresp,
  output logic [ID_W-1:0]     m1_bid,
  // Slave-side port
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [ID_W-1:0]     s_arid,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rlast,
  input  logic [ID_W-1:0]     s_rid,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [ID_W-1:0]     s_awid,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wlast,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [1:0]          s_bresp,
  input  logic [ID_W-1:0]     s_bid
);

  rd_state_t  state;
  rd_state_t  state_next;
  logic       wr_pend;
  logic       last_grant;
  logic       pick;
  logic [1:0] req;

  // LSU reads are only candidates once no write response is outstanding.
  assign req = {m1_arvalid & ~wr_pend, m0_arvalid};

  arb_pick2 u_pick (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  // Read FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Remember who won the last accepted address; reset favours m0 next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (s_arvalid && s_arready) begin
      last_grant <= (state == AR1);
    end
  end

  // Track an LSU write whose B response has not arrived; a new AW beats a same-cycle B.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_pend <= 1'b0;
    end else if (s_awvalid && s_awready) begin
      wr_pend <= 1'b1;
    end else if (s_bvalid && s_bready) begin
      wr_pend <= 1'b0;
    end
  end

  // Next-state and handshake routing; the burst ends on the slave's rlast beat.
  always_comb begin
    state_next = state;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_arvalid  = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    s_rready   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_next = pick ? AR1 : AR0;
        end
      end
      AR0: begin
        s_arvalid  = m0_arvalid;
        m0_arready = s_arready;
        if (m0_arvalid && s_arready) begin
          state_next = R0;
        end
      end
      AR1: begin
        s_arvalid  = m1_arvalid;
        m1_arready = s_arready;
        if (m1_arvalid && s_arready) begin
          state_next = R1;
        end
      end
      R0: begin
        m0_rvalid = s_rvalid;
        s_rready  = m0_rready;
        if (s_rvalid && m0_rready && s_rlast) begin
          state_next = IDLE;
        end
      end
      R1: begin
        m1_rvalid = s_rvalid;
        s_rready  = m1_rready;
        if (s_rvalid && m1_rready && s_rlast) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address payload follows the master being served; m0 otherwise (slave ignores it without arvalid).
  assign s_araddr  = (state == AR1) ? m1_araddr  : m0_araddr;
  assign s_arid    = (state == AR1) ? m1_arid    : m0_arid;
  assign s_arlen   = (state == AR1) ? m1_arlen   : m0_arlen;
  assign s_arsize  = (state == AR1) ? m1_arsize  : m0_arsize;
  assign s_arburst = (state == AR1) ? m1_arburst : m0_arburst;

  // Read data is broadcast; only the served master sees rvalid.
  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m0_rlast = s_rlast;
  assign m0_rid   = s_rid;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_rlast = s_rlast;
  assign m1_rid   = s_rid;

  // LSU write channels pass straight through.
  assign s_awvalid  = m1_awvalid;
  assign m1_awready = s_awready;
  assign s_awaddr   = m1_awaddr;
  assign s_awid     = m1_awid;
  assign s_awlen    = m1_awlen;
  assign s_awsize   = m1_awsize;
  assign s_awburst  = m1_awburst;
  assign s_wvalid   = m1_wvalid;
  assign m1_wready  = s_wready;
  assign s_wdata    = m1_wdata;
  assign s_wstrb    = m1_wstrb;
  assign s_wlast    = m1_wlast;
  assign m1_bvalid  = s_bvalid;
  assign s_bready   = m1_bready;
  assign m1_bresp   = s_bresp;
  assign m1_bid     = s_bid;

endmodule
